// File: rtl/uart_rx_deframer_pkg.sv
// Shared UART types and helpers: receiver state encoding and the baud tick divider calculation.
// Pure declarations; no latency or backpressure of its own.
package uart_pkg;

    localparam int DEFAULT_SAMP_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    function automatic int uart_div(input int clk_hz, input int baud, input int spb);
        return clk_hz / (spb * baud);
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Consumer-side bundle of the UART receiver: byte valid/ready handshake plus status pulses.
// master = receiver (drives byte/status), slave = consumer (drives ready_in).
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 ready_in;
    logic                 busy_out;
    logic                 frame_err_out;
    logic                 overrun_out;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_out;
`endif

    modport master (
        input  ready_in,
        output data_out, valid_out, busy_out, frame_err_out, overrun_out
`ifdef UART_RX_PARITY_EN
        , parity_err_out
`endif
    );

    modport slave (
        output ready_in,
        input  data_out, valid_out, busy_out, frame_err_out, overrun_out
`ifdef UART_RX_PARITY_EN
        , parity_err_out
`endif
    );
endinterface

// File: rtl/uart_rx_deframer_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks (count==0), reloading DIV-1.
// Latency: first tick DIV clocks after reset release; no backpressure.
module uart_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk_in,
    input  logic rst_n_in,
    output logic tick
);
    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)          count <= RELOAD;
        else if (count == '0)   count <= RELOAD;
        else                    count <= count - 1'b1;
    end

    assign tick = (count == '0);
endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART deframer: mid-bit sampling of samp_in, byte held on valid/ready; build option UART_RX_PARITY_EN.
// Latency: byte valid 1 clk after the stop-bit mid-point tick; new bytes overwrite an unaccepted one (overrun pulse).
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int SAMP_PER_BIT = DEFAULT_SAMP_PER_BIT,
    parameter int DATA_BITS    = 8
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic      clk_in,
    input  logic      rst_n_in,
    input  logic      samp_in,
    uart_rx_if.master rx
);
    localparam int            DIV      = uart_div(CLK_HZ, BAUD_RATE, SAMP_PER_BIT);
    localparam int            TW       = $clog2(SAMP_PER_BIT);
    localparam int            BW       = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_M1  = TW'(SAMP_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(SAMP_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic tick;

    uart_tick_gen #(.DIV(DIV)) u_tick (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .tick     (tick)
    );

    rx_state_t            state, state_nx;
    logic [TW-1:0]        tcnt, tcnt_nx;
    logic [BW-1:0]        bitcnt, bitcnt_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 deliver, frame_err;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err, parity_err_q;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state  <= IDLE;
            tcnt   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            state  <= state_nx;
            tcnt   <= tcnt_nx;
            bitcnt <= bitcnt_nx;
            shreg  <= shreg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tcnt_nx   = tcnt;
        bitcnt_nx = bitcnt;
        shreg_nx  = shreg;
        deliver   = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err = 1'b0;
`endif
        if (tick) begin
            case (state)
                IDLE: if (!samp_in) begin
                    state_nx = START;
                    tcnt_nx  = '0;
                end
                // Half a bit in: a start edge that has gone away was noise.
                START: if (tcnt == HALF_M1) begin
                    tcnt_nx   = '0;
                    bitcnt_nx = '0;
                    state_nx  = samp_in ? IDLE : DATA;
                end else tcnt_nx = tcnt + 1'b1;
                DATA: if (tcnt == FULL_M1) begin
                    tcnt_nx  = '0;
                    shreg_nx = {samp_in, shreg[DATA_BITS-1:1]};
                    if (bitcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else bitcnt_nx = bitcnt + 1'b1;
                end else tcnt_nx = tcnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                PARITY: if (tcnt == FULL_M1) begin
                    tcnt_nx = '0;
                    if ((^shreg ^ samp_in) != PARITY_ODD) begin
                        parity_err = 1'b1;
                        state_nx   = WAIT_HIGH;
                    end else state_nx = STOP;
                end else tcnt_nx = tcnt + 1'b1;
`endif
                STOP: if (tcnt == FULL_M1) begin
                    tcnt_nx = '0;
                    if (samp_in) begin
                        deliver  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nx  = WAIT_HIGH;
                    end
                end else tcnt_nx = tcnt + 1'b1;
                // A held-low line (break) must not be mistaken for a new start bit.
                WAIT_HIGH: if (samp_in) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err;
            overrun_q   <= deliver && valid_q && !rx.ready_in;
            if (deliver) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && rx.ready_in) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) parity_err_q <= 1'b0;
        else           parity_err_q <= parity_err;
    end
    assign rx.parity_err_out = parity_err_q;
`endif

    assign rx.data_out      = data_q;
    assign rx.valid_out     = valid_q;
    assign rx.busy_out      = (state != IDLE);
    assign rx.frame_err_out = frame_err_q;
    assign rx.overrun_out   = overrun_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: serial frames driven bit by bit, bytes scoreboarded at the handshake.
// Scaled clocking: DIV=4, 16 samples per bit, so one bit is 64 clocks.
module tb_uart_rx_deframer;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 15625;
    localparam int SPB    = 16;
    localparam int BIT    = SPB * (CLK_HZ / (SPB * BAUD));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic samp = 1'b1;

    uart_rx_if #(.DATA_BITS(8)) rx ();

    uart_rx_deframer #(
        .CLK_HZ       (CLK_HZ),
        .BAUD_RATE    (BAUD),
        .SAMP_PER_BIT (SPB),
        .DATA_BITS    (8)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .samp_in  (samp),
        .rx       (rx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes the consumer must eventually accept, plus the held slot while ready is low.
    logic [7:0] exp_q[$];
    logic [7:0] slot;
    bit         slot_vld = 0;
    bit         ready_pol = 1;
    int         fe_exp = 0, ov_exp = 0;
    int         fe_seen = 0, ov_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_deliver(input logic [7:0] b);
        if (ready_pol) exp_q.push_back(b);
        else begin
            if (slot_vld) ov_exp++;
            slot     = b;
            slot_vld = 1;
        end
    endtask

    task automatic set_ready(input bit r);
        if (r && slot_vld) begin
            exp_q.push_back(slot);
            slot_vld = 0;
        end
        ready_pol   = r;
        rx.ready_in = r;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bit);
        samp = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            samp = d[i];
            cyc(BIT);
        end
        if (stop_bit) model_deliver(d);
        else fe_exp++;
        samp = stop_bit;
        cyc(BIT);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4 * BIT && exp_q.size() != 0; i++) cyc(1);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_frame_err_cnt"}, fe_seen, fe_exp);
        check({name, "_overrun_cnt"}, ov_seen, ov_exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx.valid_out && rx.ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none at %0t", rx.data_out, $time);
                end else begin
                    check("handshake_data", int'(rx.data_out), int'(exp_q.pop_front()));
                end
            end
            if (rx.frame_err_out) fe_seen++;
            if (rx.overrun_out) ov_seen++;
        end
    end

    initial begin
        rx.ready_in = 1'b1;
        cyc(3);
        check("rst_valid", rx.valid_out, 0);
        check("rst_data", rx.data_out, 0);
        check("rst_busy", rx.busy_out, 0);
        check("rst_frame_err", rx.frame_err_out, 0);
        check("rst_overrun", rx.overrun_out, 0);
        rst_n = 1'b1;
        cyc(2 * BIT);

        send_frame(8'h55, 1'b1);
        cyc(BIT);
        drain("f55");

        send_frame(8'hA3, 1'b1);
        send_frame(8'h3C, 1'b1);
        cyc(BIT);
        drain("b2b");

        // Short low pulse well under half a bit.
        samp = 1'b0;
        cyc(8);
        check("glitch_busy", rx.busy_out, 1);
        cyc(12);
        samp = 1'b1;
        cyc(2 * BIT);
        check("glitch_idle_busy", rx.busy_out, 0);
        check("glitch_valid", rx.valid_out, 0);

        send_frame(8'h81, 1'b0);
        cyc(4 * BIT);
        check("break_busy", rx.busy_out, 1);
        check("break_valid", rx.valid_out, 0);
        check("break_frame_err", fe_seen, fe_exp);
        samp = 1'b1;
        cyc(2 * BIT);
        check("break_recovered_busy", rx.busy_out, 0);
        drain("break");

        set_ready(1'b0);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        cyc(BIT);
        check("ovr_valid", rx.valid_out, 1);
        check("ovr_data", int'(rx.data_out), int'(slot));
        check("ovr_cnt", ov_seen, ov_exp);
        set_ready(1'b1);
        drain("ovr");

        // Reset in the middle of a data field while a byte is still held.
        set_ready(1'b0);
        send_frame(8'h99, 1'b1);
        samp = 1'b0;
        cyc(BIT);
        samp = 1'b1;
        cyc(BIT);
        samp = 1'b0;
        cyc(BIT / 2);
        check("pre_rst_valid", rx.valid_out, 1);
        check("pre_rst_busy", rx.busy_out, 1);
        rst_n = 1'b0;
        #2;
        check("arst_valid", rx.valid_out, 0);
        check("arst_data", rx.data_out, 0);
        check("arst_busy", rx.busy_out, 0);
        slot_vld = 0;
        cyc(1);
        rst_n = 1'b1;
        samp  = 1'b1;
        cyc(12 * BIT);
        set_ready(1'b1);
        send_frame(8'h7E, 1'b1);
        cyc(BIT);
        drain("post_rst");

        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            bit ok;
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 3) == 0) set_ready(!ready_pol);
            send_frame(b, ok);
            if (!ok) begin
                samp = 1'b1;
                cyc(BIT);
            end
            cyc($urandom_range(0, 100));
        end
        set_ready(1'b1);
        cyc(BIT);
        drain("random");
        check("final_busy", rx.busy_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
